// File: rtl/axil_bresp_queue.sv
// AXI4-Lite write-response queue: buffers DEPTH backend responses and replays them in order on B.
// Optional stall watchdog enabled by defining AXIL_BRESP_WDOG_EN.
module axil_bresp_queue #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned RESP_WIDTH  = 2,
    parameter int unsigned WDOG_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   WRESPREADY,
    input  logic [RESP_WIDTH-1:0]  WRESP,
    output logic                   WRESPACCEPT,
    output logic                   BVALID,
    output logic [RESP_WIDTH-1:0]  BRESP,
    input  logic                   BREADY,
    output logic                   BRESPREADY,
    output logic [$clog2(DEPTH):0] RESP_COUNT,
    output logic                   OVERFLOW,
    output logic                   WDOG_EXPIRED
);

    localparam int unsigned CNT_WIDTH = $clog2(DEPTH) + 1;
    localparam int unsigned PTR_WIDTH = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("axil_bresp_queue: DEPTH must be a power of 2 and >= 2");
    end
    if (WDOG_CYCLES < 2) begin : g_bad_wdog
        $error("axil_bresp_queue: WDOG_CYCLES must be >= 2");
    end

    typedef enum logic {IDLE, SEND} state_t;

    state_t                state, state_nxt;
    logic [RESP_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr, wr_ptr_nxt;
    logic [PTR_WIDTH-1:0]  rd_ptr, rd_ptr_nxt;
    logic [CNT_WIDTH-1:0]  count, count_nxt;
    logic [RESP_WIDTH-1:0] bresp_nxt;
    logic [RESP_WIDTH-1:0] wresp_st;
    logic                  push, pop;

    assign RESP_COUNT = count;

    // Next-state, pointer/occupancy update and the head entry presented next cycle
    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        bresp_nxt  = '0;
        push       = WRESPREADY && WRESPACCEPT;
        pop        = BVALID && BREADY;
        // EXOKAY has no meaning on AXI4-Lite; report it as SLVERR
        wresp_st   = (WRESP == RESP_WIDTH'(1)) ? RESP_WIDTH'(2) : WRESP;

        if (push) wr_ptr_nxt = wr_ptr + PTR_WIDTH'(1);
        if (pop)  rd_ptr_nxt = rd_ptr + PTR_WIDTH'(1);

        case ({push, pop})
            2'b10:   count_nxt = count + CNT_WIDTH'(1);
            2'b01:   count_nxt = count - CNT_WIDTH'(1);
            default: count_nxt = count;
        endcase

        case (state)
            IDLE: if (push) state_nxt = SEND;
            SEND: if (pop && !push && count == CNT_WIDTH'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // The slot just written becomes the head only when the queue drains to it this edge
        if (count_nxt != '0) begin
            if (push && rd_ptr_nxt == wr_ptr) bresp_nxt = wresp_st;
            else                              bresp_nxt = mem[rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            mem         <= '{default: '0};
            BVALID      <= 1'b0;
            BRESP       <= '0;
            BRESPREADY  <= 1'b0;
            WRESPACCEPT <= 1'b1;
            OVERFLOW    <= 1'b0;
        end else begin
            state       <= state_nxt;
            wr_ptr      <= wr_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
            count       <= count_nxt;
            if (push) mem[wr_ptr] <= wresp_st;
            BVALID      <= (state_nxt == SEND);
            BRESP       <= bresp_nxt;
            BRESPREADY  <= pop;
            WRESPACCEPT <= (count_nxt != CNT_WIDTH'(DEPTH));
            if (WRESPREADY && !WRESPACCEPT) OVERFLOW <= 1'b1;
        end
    end

`ifdef AXIL_BRESP_WDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES);

    logic [WDOG_W-1:0] stall_cnt;
    logic              wdog_expired;

    assign WDOG_EXPIRED = wdog_expired;

    // Counts consecutive cycles the master leaves a valid response unaccepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt    <= '0;
            wdog_expired <= 1'b0;
        end else begin
            if (!BVALID || pop)
                stall_cnt <= '0;
            else if (stall_cnt != WDOG_W'(WDOG_CYCLES - 1))
                stall_cnt <= stall_cnt + WDOG_W'(1);
            if (stall_cnt == WDOG_W'(WDOG_CYCLES - 1)) wdog_expired <= 1'b1;
        end
    end
`else
    assign WDOG_EXPIRED = 1'b0;
`endif

endmodule

// File: tb/tb_axil_bresp_queue.sv
// Scoreboard bench for axil_bresp_queue; define AXIL_BRESP_WDOG_EN to exercise the watchdog.
module tb_axil_bresp_queue;

    localparam int unsigned DEPTH = 4;
`ifdef AXIL_BRESP_WDOG_EN
    localparam int unsigned WDOG       = 16;
    localparam logic        WDOG_AFTER = 1'b1;
`else
    localparam int unsigned WDOG       = 256;
    localparam logic        WDOG_AFTER = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       WRESPREADY = 1'b0;
    logic [1:0] WRESP = 2'b00;
    logic       BREADY = 1'b0;
    logic       WRESPACCEPT, BVALID, BRESPREADY, OVERFLOW, WDOG_EXPIRED;
    logic [1:0] BRESP;
    logic [$clog2(DEPTH):0] RESP_COUNT;

    int vectors = 0;
    int miscompares = 0;

    logic [1:0] exp_q[$];
    logic       exp_pulse = 1'b0;
    logic       exp_ovf = 1'b0;
    logic       exp_wdog = 1'b0;
    int         stall_run = 0;

    axil_bresp_queue #(.DEPTH(DEPTH), .RESP_WIDTH(2), .WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .reset(reset),
        .WRESPREADY(WRESPREADY), .WRESP(WRESP), .WRESPACCEPT(WRESPACCEPT),
        .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY), .BRESPREADY(BRESPREADY),
        .RESP_COUNT(RESP_COUNT), .OVERFLOW(OVERFLOW), .WDOG_EXPIRED(WDOG_EXPIRED)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] remap(input logic [1:0] r);
        return (r == 2'b01) ? 2'b10 : r;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        WRESPREADY = 1'b0;
        BREADY     = 1'b1;
        step(DEPTH + 2);
        BREADY     = 1'b0;
    endtask

    // Negedge monitor: compare outputs to the model, then apply the upcoming edge to the model
    always @(negedge clk) begin
        if (reset) begin
            check_eq("rst_bvalid", 32'(BVALID), 32'd0);
            check_eq("rst_bresp", 32'(BRESP), 32'd0);
            check_eq("rst_count", 32'(RESP_COUNT), 32'd0);
            check_eq("rst_accept", 32'(WRESPACCEPT), 32'd1);
            check_eq("rst_brespready", 32'(BRESPREADY), 32'd0);
            check_eq("rst_overflow", 32'(OVERFLOW), 32'd0);
            check_eq("rst_wdog", 32'(WDOG_EXPIRED), 32'd0);
            exp_q.delete();
            exp_pulse = 1'b0;
            exp_ovf   = 1'b0;
            exp_wdog  = 1'b0;
            stall_run = 0;
        end else begin
            automatic int  cnt     = exp_q.size();
            automatic logic do_pop  = (cnt > 0) && BREADY;
            automatic logic do_push = WRESPREADY && (cnt < DEPTH);
            check_eq("bvalid", 32'(BVALID), 32'(cnt > 0));
            check_eq("count", 32'(RESP_COUNT), 32'(cnt));
            check_eq("accept", 32'(WRESPACCEPT), 32'(cnt != DEPTH));
            check_eq("brespready", 32'(BRESPREADY), 32'(exp_pulse));
            check_eq("overflow", 32'(OVERFLOW), 32'(exp_ovf));
            check_eq("wdog", 32'(WDOG_EXPIRED), 32'(exp_wdog));
            if (cnt > 0) check_eq("bresp", 32'(BRESP), 32'(exp_q[0]));
            if (WRESPREADY && cnt == DEPTH) exp_ovf = 1'b1;
            if (cnt > 0 && !BREADY) stall_run++;
            else                    stall_run = 0;
            if (stall_run >= WDOG) exp_wdog = 1'b1;
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(remap(WRESP));
            exp_pulse = do_pop;
        end
    end

    initial begin
        logic [1:0] seq [4];
        seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b00;

        #1 reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(1);

        // Single push with the master ready
        WRESPREADY = 1'b1; WRESP = 2'b00; BREADY = 1'b1;
        step(1);
        WRESPREADY = 1'b0;
        check_eq("single_bvalid", 32'(BVALID), 32'd1);
        check_eq("single_bresp", 32'(BRESP), 32'd0);
        step(1);
        check_eq("single_pulse", 32'(BRESPREADY), 32'd1);
        check_eq("single_count", 32'(RESP_COUNT), 32'd0);
        step(1);
        check_eq("single_pulse_end", 32'(BRESPREADY), 32'd0);

        // Fill to DEPTH, overflow, then a refused push in the same cycle as a pop
        BREADY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            WRESPREADY = 1'b1; WRESP = seq[i];
            step(1);
        end
        check_eq("full_accept", 32'(WRESPACCEPT), 32'd0);
        check_eq("full_count", 32'(RESP_COUNT), 32'd4);
        WRESP = 2'b11;
        step(1);
        check_eq("ovf_set", 32'(OVERFLOW), 32'd1);
        BREADY = 1'b1; WRESP = 2'b01;
        step(1);
        check_eq("full_pop_refused", 32'(RESP_COUNT), 32'd3);
        drain();

        // EXOKAY remapped to SLVERR
        WRESPREADY = 1'b1; WRESP = 2'b01;
        step(1);
        WRESPREADY = 1'b0;
        check_eq("remap_bresp", 32'(BRESP), 32'd2);
        drain();

        // Long stall with a push behind the presented entry
        WRESPREADY = 1'b1; WRESP = 2'b11;
        step(1);
        WRESP = 2'b01;
        step(1);
        WRESPREADY = 1'b0;
        step(10);
        check_eq("stall_bresp", 32'(BRESP), 32'd3);
        BREADY = 1'b1;
        step(1);
        BREADY = 1'b0;
        check_eq("stall_next", 32'(BRESP), 32'd2);
        drain();

        // Simultaneous push and pop at count==1
        WRESPREADY = 1'b1; WRESP = 2'b00;
        step(1);
        WRESP = 2'b11; BREADY = 1'b1;
        step(1);
        WRESPREADY = 1'b0; BREADY = 1'b0;
        check_eq("sim_count", 32'(RESP_COUNT), 32'd1);
        check_eq("sim_bvalid", 32'(BVALID), 32'd1);
        check_eq("sim_bresp", 32'(BRESP), 32'd3);

        // Steady push/pop across pointer wraps, then random traffic
        BREADY = 1'b1; WRESPREADY = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            WRESP = 2'(i);
            step(1);
        end
        for (int i = 0; i < 12 * DEPTH; i++) begin
            WRESPREADY = 1'($urandom_range(0, 1));
            WRESP      = 2'($urandom_range(0, 3));
            BREADY     = ($urandom_range(0, 3) != 0);
            step(1);
        end
        drain();

        // Watchdog: one entry left unaccepted for WDOG-scale stall
        WRESPREADY = 1'b1; WRESP = 2'b10;
        step(1);
        WRESPREADY = 1'b0;
        step(16);
        check_eq("wdog_after_stall", 32'(WDOG_EXPIRED), 32'(WDOG_AFTER));
        BREADY = 1'b1; WRESPREADY = 1'b1; WRESP = 2'b00;
        step(3);
        WRESPREADY = 1'b0;
        step(2);
        check_eq("wdog_sticky", 32'(WDOG_EXPIRED), 32'(WDOG_AFTER));

        // Fill past full, then asynchronous reset mid-cycle
        BREADY = 1'b0; WRESPREADY = 1'b1; WRESP = 2'b11;
        step(DEPTH + 1);
        WRESPREADY = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("async_bvalid", 32'(BVALID), 32'd0);
        check_eq("async_count", 32'(RESP_COUNT), 32'd0);
        check_eq("async_overflow", 32'(OVERFLOW), 32'd0);
        check_eq("async_accept", 32'(WRESPACCEPT), 32'd1);
        check_eq("async_wdog", 32'(WDOG_EXPIRED), 32'd0);
        step(1);
        reset = 1'b0;

        // BREADY while empty: no pulse
        BREADY = 1'b1;
        step(4);
        check_eq("empty_pulse", 32'(BRESPREADY), 32'd0);
        BREADY = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axil_bresp_queue.md
Name: axil_bresp_queue

Overview:
Parametrised successor to the single-entry AXI4-Lite write-response channel. It buffers up to DEPTH write responses from the memory/backend side in a FIFO and presents them in order on the B channel with a full VALID/READY handshake. Each response is held stable until the master accepts it. The block sits between the write-datapath/memory interface (WDONE/WRESP-style producer) and the AXI4-Lite master port.

Parameters:
DEPTH, 4, number of buffered responses; power of 2, >= 2
RESP_WIDTH, 2, response code width; fixed at 2 for AXI4-Lite
CNT_WIDTH, $clog2(DEPTH)+1, width of the occupancy count; localparam, not overridable
WDOG_CYCLES, 256, stall-watchdog threshold in cycles; used only with the optional feature

Ports:
clk  input  1  clock; all logic on the rising edge
reset  input  1  asynchronous, active-high reset
WRESPREADY  input  1  producer push strobe; a response is presented this cycle
WRESP  input  RESP_WIDTH  response code from the backend
WRESPACCEPT  output  1  queue can accept a push this cycle (not full)
BVALID  output  1  B-channel valid to the master
BRESP  output  RESP_WIDTH  B-channel response to the master
BREADY  input  1  master ready
BRESPREADY  output  1  one-cycle pulse after each completed B handshake
RESP_COUNT  output  CNT_WIDTH  entries currently held, 0..DEPTH
OVERFLOW  output  1  sticky flag: push attempted while full
WDOG_EXPIRED  output  1  sticky stall-watchdog flag; tied 0 when the feature is disabled

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs return to their reset values on reset assertion, without waiting for a clock edge.
  - Reset values: BVALID=0, BRESP=2'b00, BRESPREADY=0, RESP_COUNT=0, OVERFLOW=0, WDOG_EXPIRED=0, WRESPACCEPT=1.
  - Pointers clear; queued entries are discarded.
- Storage: DEPTH x RESP_WIDTH register array with wr_ptr and rd_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH. Occupancy is held in a CNT_WIDTH counter.
- Push:
  - Occurs on a rising edge where WRESPREADY=1 and WRESPACCEPT=1.
  - Stores WRESP at wr_ptr, then advances wr_ptr.
  - WRESPACCEPT = (count != DEPTH), derived from registered state only.
- Response remap: WRESP 2'b01 (EXOKAY, illegal in AXI4-Lite) is stored as 2'b10 (SLVERR). Codes 00, 10 and 11 are stored unchanged.
- Output FSM, two states:
  - IDLE (count==0): BVALID=0.
  - SEND (count>0): BVALID=1, BRESP=mem[rd_ptr].
  - Transitions: IDLE->SEND on a push. SEND->IDLE on a pop when count==1 and there is no simultaneous push. Otherwise the FSM stays in SEND.
- Pop:
  - Occurs on a rising edge where BVALID=1 and BREADY=1.
  - rd_ptr advances; BRESPREADY is registered high for exactly the following cycle.
- Latency: a push into an empty queue gives BVALID=1 in the next cycle. There is no combinational bypass from WRESP to BRESP.
- Stability: while BVALID=1 and BREADY=0, BVALID and BRESP do not change. A push in this situation does not disturb the presented entry.
- Simultaneous push and pop:
  - Count is unchanged, and both pointers advance.
  - When count==1, BVALID stays high and BRESP shows the new entry in the next cycle.
- Full:
  - A push is refused even if a pop occurs in the same cycle, because WRESPACCEPT is computed from registered state.
  - WRESPREADY=1 while full leaves storage unchanged and sets OVERFLOW=1 until reset.
- Empty: BREADY has no effect while empty, and no BRESPREADY pulse is generated.
- Wrap-around: the pointers wrap modulo DEPTH. FIFO ordering holds across any number of wraps.

Optional Feature:
Macro: AXIL_BRESP_WDOG_EN.
- Defined:
  - A stall counter increments each cycle where BVALID=1 and BREADY=0. It clears on a pop or when BVALID=0, and saturates.
  - When the counter reaches WDOG_CYCLES-1, WDOG_EXPIRED is set and stays set until reset.
  - The queue keeps operating normally after expiry.
- Not defined: there is no counter logic, and WDOG_EXPIRED is tied to 0.

Test Plan:
- Reset, then a single push of WRESP=00 with BREADY=1 -> BVALID=1 one cycle after the push; BRESP=00; handshake completes; BRESPREADY pulses once for 1 cycle; RESP_COUNT returns 0.
- With DEPTH=4 and BREADY=0, push 00,10,11,00 -> WRESPACCEPT=0; RESP_COUNT=4; a 5th push sets OVERFLOW=1 and is not stored. Raise BREADY -> BRESP sequence is 00,10,11,00, then BVALID=0.
- Push WRESP=01 -> BRESP presented as 10.
- Hold BREADY=0 for 10 cycles while pushing one more entry -> BVALID and BRESP stay constant throughout; the new entry appears only after the current handshake.
- Count==1 with simultaneous push(11) and pop -> RESP_COUNT stays 1; BVALID stays high; BRESP=11 in the next cycle. Then run 3*DEPTH push/pop cycles -> ordering is preserved across pointer wraps.
- With AXIL_BRESP_WDOG_EN, WDOG_CYCLES=16, BVALID=1 and BREADY=0 for 16 cycles -> WDOG_EXPIRED=1. Later handshakes leave it set. Asserting reset mid-queue clears all state and flags immediately.
